// File: rtl/gemm_c_drain.sv
// gemm_c_drain: reads the tiled GeMM result matrix C back from SRAM C and
// streams its elements one per beat in full-matrix row-major order.
// Optional feature macro: DRAIN_SAT_EN. When it is defined, each element
// saturates to the signed stream range. Otherwise each element is truncated
// to its low StreamWidth bits.
module gemm_c_drain #(
  parameter int unsigned OutDataWidth  = 32,
  parameter int unsigned StreamWidth   = 16,
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned M             = 4,
  parameter int unsigned N             = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [SizeAddrWidth-1:0]        M_size_i,
  input  logic [SizeAddrWidth-1:0]        N_size_i,
  output logic [AddrWidth-1:0]            sram_c_addr_o,
  output logic                            sram_c_re_o,
  input  logic [OutDataWidth*M*N-1:0]     sram_c_rdata_i,
  output logic [StreamWidth-1:0]          out_data_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            out_eol_o,
  output logic                            out_last_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned NIdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, RD, CAP, EMIT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   m_size_q, m_size_d, n_size_q, n_size_d;
  logic [AddrWidth-1:0]   tm_q, tm_d, m_q, m_d, tn_q, tn_d, n_q, n_d;
  logic [AddrWidth-1:0]   m_tiles, n_tiles;
  logic                   n_last, tn_last, m_last, tm_last;
  logic                   load_row;
  logic [StreamWidth-1:0] cap_row   [N];
  logic [StreamWidth-1:0] row_buf_q [N];

  // Narrow one stored element to the stream width.
  function automatic logic [StreamWidth-1:0] narrow(input logic [OutDataWidth-1:0] v);
`ifdef DRAIN_SAT_EN
    localparam logic [OutDataWidth-1:0] SatMax =
      {{(OutDataWidth-StreamWidth+1){1'b0}}, {(StreamWidth-1){1'b1}}};
    localparam logic [OutDataWidth-1:0] SatMin =
      {{(OutDataWidth-StreamWidth+1){1'b1}}, {(StreamWidth-1){1'b0}}};
    if ($signed(v) > $signed(SatMax))      return StreamWidth'(SatMax);
    else if ($signed(v) < $signed(SatMin)) return StreamWidth'(SatMin);
    else                                   return StreamWidth'(v);
`else
    return StreamWidth'(v);
`endif
  endfunction

  assign m_tiles = m_size_q / AddrWidth'(M);
  assign n_tiles = n_size_q / AddrWidth'(N);
  assign n_last  = (n_q == AddrWidth'(N - 1));
  assign tn_last = (tn_q == n_tiles - AddrWidth'(1));
  assign m_last  = (m_q == AddrWidth'(M - 1));
  assign tm_last = (tm_q == m_tiles - AddrWidth'(1));

  // Pick tile row m out of the SRAM word and narrow its N elements.
  always_comb begin
    for (int j = 0; j < N; j++) cap_row[j] = '0;
    for (int mi = 0; mi < M; mi++) begin
      if (m_q == AddrWidth'(mi)) begin
        for (int j = 0; j < N; j++) begin
          cap_row[j] = narrow(sram_c_rdata_i[(mi*N + j)*OutDataWidth +: OutDataWidth]);
        end
      end
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    m_size_d = m_size_q;
    n_size_d = n_size_q;
    tm_d     = tm_q;
    m_d      = m_q;
    tn_d     = tn_q;
    n_d      = n_q;
    load_row = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          m_size_d = AddrWidth'(M_size_i);
          n_size_d = AddrWidth'(N_size_i);
          tm_d     = '0;
          m_d      = '0;
          tn_d     = '0;
          n_d      = '0;
          state_d  = (M_size_i == '0 || N_size_i == '0) ? DONE : RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        load_row = 1'b1;
        state_d  = EMIT;
      end
      EMIT: begin
        if (out_ready_i) begin
          if (n_last) begin
            n_d     = '0;
            state_d = RD;
            if (tn_last) begin
              tn_d = '0;
              if (m_last) begin
                m_d = '0;
                if (tm_last) state_d = DONE;
                else         tm_d    = tm_q + AddrWidth'(1);
              end else begin
                m_d = m_q + AddrWidth'(1);
              end
            end else begin
              tn_d = tn_q + AddrWidth'(1);
            end
          end else begin
            n_d = n_q + AddrWidth'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, size and loop counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    if (!rst_ni) begin
      state_q  <= IDLE;
      m_size_q <= '0;
      n_size_q <= '0;
      tm_q     <= '0;
      m_q      <= '0;
      tn_q     <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      m_size_q <= m_size_d;
      n_size_q <= n_size_d;
      tm_q     <= tm_d;
      m_q      <= m_d;
      tn_q     <= tn_d;
      n_q      <= n_d;
    end
  end

  // Row buffer, loaded in CAP with the narrowed elements of tile row m.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: this small buffer is reset because out_data_o reads it directly and must be 0 after reset.
    if (!rst_ni) begin
      for (int j = 0; j < N; j++) row_buf_q[j] <= '0;
    end else if (load_row) begin
      for (int j = 0; j < N; j++) row_buf_q[j] <= cap_row[j];
    end
  end

  assign sram_c_re_o   = (state_q == RD);
  assign sram_c_addr_o = (state_q == RD) ? (tm_q * n_tiles + tn_q) : '0;
  assign out_valid_o   = (state_q == EMIT);
  assign out_data_o    = row_buf_q[n_q[NIdxW-1:0]];
  assign out_eol_o     = out_valid_o && tn_last && n_last;
  assign out_last_o    = out_eol_o && tm_last && m_last;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_gemm_c_drain.sv
// Self-checking bench for gemm_c_drain: table-driven transfers plus
// hand-written reset-abort and reset-state sequences.
module tb_gemm_c_drain;

  localparam int ODW   = 32;
  localparam int SW    = 16;
  localparam int AW    = 16;
  localparam int SAW   = 8;
  localparam int M     = 4;
  localparam int N     = 4;
  localparam int WordW = ODW * M * N;

  typedef struct {
    int m_size;
    int n_size;
    int ready_mode;  // 0: ready held high, 1: ready toggles every cycle
    int glitch;      // 1: pulse start with other sizes mid-run
    int sat;         // 1: first four elements use the out-of-range pattern
    int exp_beats;
    int exp_cycles;  // start cycle through done cycle inclusive, -1 = skip
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start = 1'b0;
  logic [SAW-1:0]  m_size = '0;
  logic [SAW-1:0]  n_size = '0;
  logic [AW-1:0]   addr;
  logic            re;
  logic [WordW-1:0] rdata = '0;
  logic [SW-1:0]   data;
  logic            valid, eol, last, busy, done;
  logic            ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_mode = 0;

  logic [SW-1:0] beat_data [$];
  bit            beat_eol  [$];
  bit            beat_last [$];
  int            re_addr   [$];
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            first_valid_cyc = -1;
  bit            prev_stall = 1'b0;
  logic [SW-1:0] prev_data;
  logic          prev_eol, prev_last;

  logic [WordW-1:0] mem [16];

  always #5 clk = ~clk;

  gemm_c_drain dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start),
    .M_size_i       (m_size),
    .N_size_i       (n_size),
    .sram_c_addr_o  (addr),
    .sram_c_re_o    (re),
    .sram_c_rdata_i (rdata),
    .out_data_o     (data),
    .out_valid_o    (valid),
    .out_ready_i    (ready),
    .out_eol_o      (eol),
    .out_last_o     (last),
    .busy_o         (busy),
    .done_o         (done)
  );

  // SRAM C model with one cycle of read latency.
  always @(posedge clk) if (re) rdata <= mem[addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready driver.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) ready = ~ready;
    else                 ready = 1'b1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stream monitor: records beats, reads and done pulses; checks stall stability.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (prev_stall) begin
        check("stall_valid", valid, 1);
        check("stall_data", data, prev_data);
        check("stall_eol", eol, prev_eol);
        check("stall_last", last, prev_last);
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_eol   = eol;
      prev_last  = last;
      if (valid && ready) begin
        beat_data.push_back(data);
        beat_eol.push_back(eol);
        beat_last.push_back(last);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (re) re_addr.push_back(int'(addr));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Element value stored at C[r][c].
  function automatic int c_value(input int r, input int c, input int ns, input int sat);
    if (sat != 0 && r == 0 && c < 4) begin
      case (c)
        0:       return 70000;
        1:       return -70000;
        2:       return 32767;
        default: return -32768;
      endcase
    end
    return r * ns + c;
  endfunction

  // Expected emitted value for row-major element k.
  function automatic int exp_value(input int k, input int sat);
    if (sat != 0 && k < 4) begin
`ifdef DRAIN_SAT_EN
      case (k)
        0:       return 32767;
        1:       return -32768;
        2:       return 32767;
        default: return -32768;
      endcase
`else
      case (k)
        0:       return 4464;
        1:       return -4464;
        2:       return 32767;
        default: return -32768;
      endcase
`endif
    end
    return k;
  endfunction

  task automatic fill_mem(input int ms, input int ns, input int sat);
    for (int a = 0; a < 16; a++) mem[a] = '0;
    for (int r = 0; r < ms; r++) begin
      for (int c = 0; c < ns; c++) begin
        mem[(r / M) * (ns / N) + (c / N)][((r % M) * N + (c % N)) * ODW +: ODW] =
          ODW'(c_value(r, c, ns, sat));
      end
    end
  endtask

  task automatic clear_obs();
    beat_data.delete();
    beat_eol.delete();
    beat_last.delete();
    re_addr.delete();
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
  endtask

  task automatic pulse_start(input int ms, input int ns, output int start_cyc);
    @(posedge clk); #1;
    start  = 1'b1;
    m_size = SAW'(ms);
    n_size = SAW'(ns);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int start_cyc;
    int dummy;
    int groups;
    int nt;
    int k;
    fill_mem(v.m_size, v.n_size, v.sat);
    clear_obs();
    ready_mode = v.ready_mode;
    pulse_start(v.m_size, v.n_size, start_cyc);
    if (v.glitch != 0) begin
      repeat (6) @(posedge clk);
      pulse_start(8, 8, dummy);
    end
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    check("done_timeout", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("beat_count", beat_data.size(), v.exp_beats);
    k = 0;
    while (k < beat_data.size() && k < v.exp_beats) begin
      check("beat_data", longint'($signed(beat_data[k])), exp_value(k, v.sat));
      check("beat_eol", beat_eol[k], (k % v.n_size) == v.n_size - 1);
      check("beat_last", beat_last[k], k == v.exp_beats - 1);
      k++;
    end
    groups = v.exp_beats / N;
    nt     = (v.n_size > 0) ? v.n_size / N : 1;
    check("read_count", re_addr.size(), groups);
    for (int g = 0; g < groups && g < re_addr.size(); g++) begin
      check("read_addr", re_addr[g], (g / (nt * M)) * nt + (g % nt));
    end
    if (v.exp_cycles > 0) check("done_latency", done_cyc - start_cyc + 1, v.exp_cycles);
    if (v.exp_beats > 0 && v.ready_mode == 0)
      check("first_valid_latency", first_valid_cyc - start_cyc, 3);
    ready_mode = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_re"}, re, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_eol"}, eol, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    vec_t vecs [8];
    int   dummy;
    vecs[0] = '{4, 4, 0, 0, 0, 16, 26};
    vecs[1] = '{8, 8, 0, 0, 0, 64, 98};
    vecs[2] = '{4, 4, 1, 0, 0, 16, -1};
    vecs[3] = '{0, 4, 0, 0, 0, 0, 2};
    vecs[4] = '{4, 0, 0, 0, 0, 0, 2};
    vecs[5] = '{4, 4, 0, 1, 0, 16, 26};
    vecs[6] = '{4, 4, 0, 0, 1, 16, 26};
    vecs[7] = '{8, 4, 0, 0, 0, 32, 50};

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #1 rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // Reset mid-transfer: abort after five beats, no done pulse.
    fill_mem(4, 4, 0);
    clear_obs();
    pulse_start(4, 4, dummy);
    for (int i = 0; i < 200 && beat_data.size() < 5; i++) begin
      @(negedge clk); #1;
    end
    check("abort_reached_5_beats", beat_data.size() >= 5, 1);
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (2) @(negedge clk);
    #1 rst_ni = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);

    // A fresh start after the abort reproduces the full sequence.
    run(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_c_drain.md
# gemm_c_drain

Read-side companion of the GeMM accelerator's output SRAM. After a GeMM run completes, it reads the tiled result matrix C back from SRAM C, one M×N tile word per read. It emits the elements one at a time on a valid/ready stream in full-matrix row-major order. It sits between SRAM C and the host/DMA result path.

## Interface
- OutDataWidth, 32, width of one C element as stored in SRAM C
- StreamWidth, 16, width of one emitted element (≤ OutDataWidth)
- AddrWidth, 16, SRAM C address width
- SizeAddrWidth, 8, width of matrix size inputs
- M, 4, tile rows per SRAM C word
- N, 4, tile columns per SRAM C word
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; sizes sampled on the same cycle
- M_size_i  in  SizeAddrWidth  total rows of C (multiple of M)
- N_size_i  in  SizeAddrWidth  total columns of C (multiple of N)
- sram_c_addr_o  out  AddrWidth  SRAM C read address
- sram_c_re_o  out  1  SRAM C read enable
- sram_c_rdata_i  in  OutDataWidth*M*N  tile word; element (m,n) at bits [(m*N+n)*OutDataWidth +: OutDataWidth]
- out_data_o  out  StreamWidth  element value, signed
- out_valid_o  out  1  element valid
- out_ready_i  in  1  consumer ready
- out_eol_o  out  1  element is the last of a matrix row
- out_last_o  out  1  element is the last of the matrix
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse after the final beat

## Operation
- FSM states: IDLE, RD, CAP, EMIT, DONE.
- IDLE: start_i=1 latches M_size_i/N_size_i and clears counters tm, m, tn, n. Next state is RD. If either size is 0, next state is DONE and no beats are emitted.
- start_i outside IDLE is ignored, and latched sizes do not change.
- RD: sram_c_re_o=1, sram_c_addr_o = tm*(N_size/N) + tn. This is the same row-major tile layout the accelerator writes.
- CAP: sram_c_rdata_i is valid. The N elements of tile row m are registered into an N-entry buffer at the end of the cycle.
- EMIT: buffer[n] is presented. A beat completes when out_valid_o && out_ready_i. n increments on each beat.
  - After beat n=N-1: tn++.
  - When tn wraps: m++.
  - When m wraps: tm++.
  - Next state is RD, or DONE after the last beat.
- Loop order (outer→inner): tm, m, tn, n. Emitted element index = (tm*M+m)*N_size + tn*N + n. Each tile is re-read M times.
- out_eol_o=1 when tn=N_size/N-1 and n=N-1.
- out_last_o=1 when out_eol_o=1 and tm=M_size/M-1 and m=M-1.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- Width: the low StreamWidth bits of each element are emitted, unless DRAIN_SAT_EN is defined (see Configuration).
- Counter and address arithmetic is done at AddrWidth. Sizes are assumed to be exact multiples of M/N, with no checking.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, buffer 0.
- Reset mid-transfer aborts immediately. No done_o pulse is produced.
- start_i at cycle t → RD (addr/re) at t+1 → CAP at t+2 → first out_valid_o at t+3.
- Each tile-row group costs 2 bubble cycles (RD, CAP) plus N beats.
- With out_ready_i held at 1, total cycles start→done_o = 1 + (M_size*N_size/N)*(N+2) + 1.
- out_valid_o is high only in EMIT.
- While out_ready_i=0, out_data_o/out_eol_o/out_last_o stay stable, and the stream does not advance.
- out_valid_o never drops without a handshake.
- The SRAM has 1-cycle read latency. sram_c_re_o is high only in RD and for exactly one cycle per group.
- done_o rises the cycle after the last handshake.

## Configuration
- DRAIN_SAT_EN defined: each element saturates to the signed StreamWidth range.
  - Value > 2^(StreamWidth-1)-1 → max.
  - Value < -2^(StreamWidth-1) → min.
  - Otherwise passed unchanged.
- DRAIN_SAT_EN undefined: each element is truncated to its low StreamWidth bits.
- StreamWidth = OutDataWidth makes both modes identical.

## Test plan
- M=N=4, M_size=N_size=4, C[r][c]=r*4+c, ready always 1 → 16 beats with values 0..15 in order. eol on values 3,7,11,15; last on 15. done_o at cycle start+1+4*6+1 = start+26.
- M_size=8, N_size=8, C[r][c]=r*8+c → 64 beats 0..63 in order. Address sequence per tm is 2tm, 2tm+1, repeated 4 times. out_last_o only on value 63.
- Same as the first scenario, with out_ready_i toggling 0/1 every cycle → identical 16-value sequence. Data is stable while stalled. No duplicate or dropped beats.
- M_size=0 → no sram_c_re_o, no beats, done_o at start+2. start_i pulsed while busy in another run → ignored.
- C element = 70000 and -70000 with StreamWidth=16 → sat build emits 32767/-32768; non-sat build emits 4464 and -4464 (low 16 bits).
- rst_ni asserted after 5 beats → all outputs 0 immediately, no done_o. A new start then reproduces the full sequence from element 0.
